// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: round-robin
// grant between ALU and LSU, registered write stage, read-hazard forwarding flags, halt sequencing.
module rf_wb_arbiter #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DROP_R0 = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             HLT,
  input  logic             A_VALID,
  output logic             A_READY,
  input  logic [AW-1:0]    A_DR,
  input  logic [DW-1:0]    A_DATA,
  input  logic             L_VALID,
  output logic             L_READY,
  input  logic [AW-1:0]    L_DR,
  input  logic [DW-1:0]    L_DATA,
  input  logic [AW-1:0]    SR1,
  input  logic [AW-1:0]    SR2,
  output logic             RegW,
  output logic [AW-1:0]    DR,
  output logic [DW-1:0]    Reg_In,
  output logic             FWD1,
  output logic             FWD2,
  output logic [DW-1:0]    FWD_DATA,
  output logic             HALTED,
  output logic [CNT_W-1:0] CONFLICT_CNT
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t          state, state_nx;
  logic            pri;
  logic            run_ok, accept;
  logic [AW-1:0]   acc_dr;
  logic [DW-1:0]   acc_data;

  always_comb begin
    run_ok   = (state == S_RUN) && !HLT;
    // pri=1 prefers LSU; a lone requester always wins
    L_READY  = run_ok && L_VALID && (!A_VALID || pri);
    A_READY  = run_ok && A_VALID && (!L_VALID || !pri);
    accept   = A_READY || L_READY;
    acc_dr   = L_READY ? L_DR   : A_DR;
    acc_data = L_READY ? L_DATA : A_DATA;

    state_nx = state;
    case (state)
      S_RUN:    if (HLT) state_nx = S_DRAIN;
      S_DRAIN:  state_nx = HLT ? S_HALTED : S_RUN;
      S_HALTED: if (!HLT) state_nx = S_RUN;
      default:  state_nx = S_RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= S_RUN;
      pri          <= 1'b1;
      HALTED       <= 1'b0;
      RegW         <= 1'b0;
      DR           <= '0;
      Reg_In       <= '0;
      FWD1         <= 1'b0;
      FWD2         <= 1'b0;
      FWD_DATA     <= '0;
      CONFLICT_CNT <= '0;
    end else begin
      state  <= state_nx;
      HALTED <= (state_nx == S_HALTED);

      if (L_READY)      pri <= 1'b0;
      else if (A_READY) pri <= 1'b1;

      // Acceptance only happens in RUN, so the resulting write always lands
      // in RUN or DRAIN and is never swallowed by a halt.
      RegW <= accept && !((DROP_R0 != 0) && (acc_dr == '0));
      if (accept) begin
        DR     <= acc_dr;
        Reg_In <= acc_data;
      end

      // The register file reads old data on the write edge; flag that read.
      FWD1     <= RegW && (DR == SR1);
      FWD2     <= RegW && (DR == SR2);
      FWD_DATA <= Reg_In;

      if (run_ok && A_VALID && L_VALID && (CONFLICT_CNT != '1))
        CONFLICT_CNT <= CONFLICT_CNT + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: stimulus pushes expected writes, a
// negedge monitor pops them whenever the write port asserts RegW.
module tb_rf_wb_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          CLK = 1'b0;
  logic          RST_N, HLT, A_VALID, L_VALID;
  logic [AW-1:0] A_DR, L_DR, SR1, SR2;
  logic [DW-1:0] A_DATA, L_DATA;

  logic          a_rdy0, l_rdy0, regw0, fwd1_0, fwd2_0, halted0;
  logic [AW-1:0] dr0;
  logic [DW-1:0] regin0, fwdd0;
  logic [15:0]   cnt0;

  logic          a_rdy1, l_rdy1, regw1, fwd1_1, fwd2_1, halted1;
  logic [AW-1:0] dr1;
  logic [DW-1:0] regin1, fwdd1;
  logic [15:0]   cnt1;

  logic          a_rdy2, l_rdy2, regw2, fwd1_2, fwd2_2, halted2;
  logic [AW-1:0] dr2;
  logic [DW-1:0] regin2, fwdd2;
  logic [1:0]    cnt2;

  rf_wb_arbiter dut0 (
    .CLK(CLK), .RST_N(RST_N), .HLT(HLT),
    .A_VALID(A_VALID), .A_READY(a_rdy0), .A_DR(A_DR), .A_DATA(A_DATA),
    .L_VALID(L_VALID), .L_READY(l_rdy0), .L_DR(L_DR), .L_DATA(L_DATA),
    .SR1(SR1), .SR2(SR2), .RegW(regw0), .DR(dr0), .Reg_In(regin0),
    .FWD1(fwd1_0), .FWD2(fwd2_0), .FWD_DATA(fwdd0), .HALTED(halted0),
    .CONFLICT_CNT(cnt0));

  rf_wb_arbiter #(.DROP_R0(0)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .HLT(HLT),
    .A_VALID(A_VALID), .A_READY(a_rdy1), .A_DR(A_DR), .A_DATA(A_DATA),
    .L_VALID(L_VALID), .L_READY(l_rdy1), .L_DR(L_DR), .L_DATA(L_DATA),
    .SR1(SR1), .SR2(SR2), .RegW(regw1), .DR(dr1), .Reg_In(regin1),
    .FWD1(fwd1_1), .FWD2(fwd2_1), .FWD_DATA(fwdd1), .HALTED(halted1),
    .CONFLICT_CNT(cnt1));

  rf_wb_arbiter #(.CNT_W(2)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .HLT(HLT),
    .A_VALID(A_VALID), .A_READY(a_rdy2), .A_DR(A_DR), .A_DATA(A_DATA),
    .L_VALID(L_VALID), .L_READY(l_rdy2), .L_DR(L_DR), .L_DATA(L_DATA),
    .SR1(SR1), .SR2(SR2), .RegW(regw2), .DR(dr2), .Reg_In(regin2),
    .FWD1(fwd1_2), .FWD2(fwd2_2), .FWD_DATA(fwdd2), .HALTED(halted2),
    .CONFLICT_CNT(cnt2));

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AW-1:0] dr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every committed write must match the oldest expected write.
  always @(negedge CLK) begin : mon
    wr_t e;
    if (RST_N === 1'b1 && regw0 === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_write: got DR=%0d data=0x%0h, expected no write", dr0, regin0);
      end else begin
        e = exp_q.pop_front();
        chk("wb_dr", {27'd0, dr0}, {27'd0, e.dr});
        chk("wb_data", regin0, e.data);
      end
    end
  end

  // One cycle: drive at posedge+1, check readies at negedge, record the
  // expected write for DUT0 (DR 0 writes are dropped), return at posedge+1.
  task automatic beat(input logic av, input logic [AW-1:0] adr, input logic [DW-1:0] ad,
                      input logic lv, input logic [AW-1:0] ldr, input logic [DW-1:0] ld,
                      input logic hlt, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                      input logic ear, input logic elr);
    A_VALID = av; A_DR = adr; A_DATA = ad;
    L_VALID = lv; L_DR = ldr; L_DATA = ld;
    HLT = hlt; SR1 = s1; SR2 = s2;
    @(negedge CLK);
    chk("a_ready", {31'd0, a_rdy0}, {31'd0, ear});
    chk("l_ready", {31'd0, l_rdy0}, {31'd0, elr});
    if (ear && adr != '0) exp_q.push_back(wr_t'{dr: adr, data: ad});
    if (elr && ldr != '0) exp_q.push_back(wr_t'{dr: ldr, data: ld});
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    beat(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned exp_c[6];
    exp_c = '{1, 2, 3, 3, 3, 3};
    RST_N = 1'b0; HLT = 1'b0; A_VALID = 1'b0; L_VALID = 1'b0;
    A_DR = '0; L_DR = '0; A_DATA = '0; L_DATA = '0; SR1 = '0; SR2 = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_regw", {31'd0, regw0}, 32'd0);
    chk("rst_dr", {27'd0, dr0}, 32'd0);
    chk("rst_regin", regin0, 32'd0);
    chk("rst_fwd1", {31'd0, fwd1_0}, 32'd0);
    chk("rst_fwd2", {31'd0, fwd2_0}, 32'd0);
    chk("rst_fwddata", fwdd0, 32'd0);
    chk("rst_halted", {31'd0, halted0}, 32'd0);
    chk("rst_cnt", {16'd0, cnt0}, 32'd0);
    RST_N = 1'b1;

    // Both requesters held: L, A, L, A
    for (int unsigned i = 0; i < 4; i++)
      beat(1'b1, 5'd3, 32'hAAAA0000, 1'b1, 5'd4, 32'h5555FFFF, 1'b0, 5'd0, 5'd0,
           (i % 2) == 1, (i % 2) == 0);
    chk("conflict_cnt4", {16'd0, cnt0}, 32'd4);
    chk("conflict_cnt_w2", {30'd0, cnt2}, 32'd3);
    idle();
    chk("q_empty_rr", exp_q.size(), 32'd0);

    // Register 0 write: accepted, dropped by default, committed with DROP_R0=0
    beat(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
    chk("r0_regw_drop", {31'd0, regw0}, 32'd0);
    chk("r0_regw_keep", {31'd0, regw1}, 32'd1);
    chk("r0_dr_keep", {27'd0, dr1}, 32'd0);
    chk("r0_data_keep", regin1, 32'h1234);

    // Forwarding: write to r7 presented while r7/r8 are read
    beat(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
    beat(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd8, 1'b0, 1'b0);
    chk("fwd1", {31'd0, fwd1_0}, 32'd1);
    chk("fwd2", {31'd0, fwd2_0}, 32'd0);
    chk("fwd_data", fwdd0, 32'hDEADBEEF);

    // Halt: accepted write commits, ready blocked, HALTED from 2nd HLT edge
    beat(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
    beat(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("drain_halted", {31'd0, halted0}, 32'd0);
    chk("drain_regw", {31'd0, regw0}, 32'd0);
    beat(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("halted_1", {31'd0, halted0}, 32'd1);
    beat(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("halted_2", {31'd0, halted0}, 32'd1);
    chk("halted_regw", {31'd0, regw0}, 32'd0);
    beat(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("unhalt", {31'd0, halted0}, 32'd0);
    beat(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
    idle();
    chk("q_empty_halt", exp_q.size(), 32'd0);

    // Fresh reset, then 6 conflict cycles against the 2-bit counter
    RST_N = 1'b0;
    #1;
    chk("rst2_cnt_w2", {30'd0, cnt2}, 32'd0);
    RST_N = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      beat(1'b1, 5'd3, 32'hAAAA0000, 1'b1, 5'd4, 32'h5555FFFF, 1'b0, 5'd0, 5'd0,
           (i % 2) == 1, (i % 2) == 0);
      chk("sat_cnt", {30'd0, cnt2}, exp_c[i]);
    end

    // L alone moves priority to A; then reset mid-stream with RegW/FWD1 high
    beat(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h5555FFFF, 1'b0, 5'd3, 5'd0, 1'b0, 1'b1);
    chk("pre_rst_regw", {31'd0, regw0}, 32'd1);
    chk("pre_rst_fwd1", {31'd0, fwd1_0}, 32'd1);
    #1;
    RST_N = 1'b0;
    #1;
    exp_q.delete();
    chk("async_rst_regw", {31'd0, regw0}, 32'd0);
    chk("async_rst_dr", {27'd0, dr0}, 32'd0);
    chk("async_rst_regin", regin0, 32'd0);
    chk("async_rst_fwd1", {31'd0, fwd1_0}, 32'd0);
    chk("async_rst_halted", {31'd0, halted0}, 32'd0);
    RST_N = 1'b1;
    beat(1'b1, 5'd3, 32'hAAAA0000, 1'b1, 5'd4, 32'h5555FFFF, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle();
    chk("q_empty_end", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Write-back arbiter and sequencer for the 32x32 register file's single write port. It takes write-back requests from the ALU and load/store unit, grants one per cycle round-robin, and drives RegW/DR/Reg_In from an output register. It also produces forwarding flags that cover the register file's registered-read hazard, and sequences a clean halt: drain, then report HALTED.

Parameters:
DW, 32, data width of write-back data
AW, 5, register address width
CNT_W, 16, width of saturating conflict counter
DROP_R0, 1, when 1 writes to register 0 are accepted but never committed

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
HLT  input  1  halt request, level
A_VALID  input  1  ALU write-back request
A_READY  output  1  ALU request accepted this cycle
A_DR  input  AW  ALU destination register
A_DATA  input  DW  ALU result
L_VALID  input  1  LSU write-back request
L_READY  output  1  LSU request accepted this cycle
L_DR  input  AW  LSU destination register
L_DATA  input  DW  LSU load data
SR1  input  AW  source register 1 presented to the register file this cycle
SR2  input  AW  source register 2 presented to the register file this cycle
RegW  output  1  register-file write enable
DR  output  AW  register-file destination
Reg_In  output  DW  register-file write data
FWD1  output  1  ReadReg1 is stale; use FWD_DATA
FWD2  output  1  ReadReg2 is stale; use FWD_DATA
FWD_DATA  output  DW  forwarded write data
HALTED  output  1  write port idle and halted
CONFLICT_CNT  output  CNT_W  cycles where both requesters were valid and one was refused

Behaviour:
- Reset (async, RST_N=0) sets outputs as follows. RegW=0, DR=0, Reg_In=0, FWD1=FWD2=0, FWD_DATA=0, HALTED=0, CONFLICT_CNT=0. Internal state goes to RUN and the priority pointer PRI=1 (LSU preferred). Any write accepted but not yet presented is discarded.
- Handshake: a transfer occurs when X_VALID and X_READY are high at a rising CLK edge. After raising VALID, a requester holds VALID, DR and DATA stable until accepted. READY may depend combinationally on VALID, HLT and state. At most one READY is high per cycle.
- Grant rules, in state RUN with HLT=0:
  - Only one VALID high: that requester gets READY.
  - Both VALID high: PRI=1 grants L, PRI=0 grants A.
  - After any grant, PRI points to the non-granted side.
  - No VALID high: PRI holds.
- Grant rule otherwise: if HLT=1 or state is not RUN, both READY=0.
- Output stage, registered with 1-cycle latency:
  - On acceptance, next cycle DR/Reg_In take the granted DR/DATA. RegW=1, except when DROP_R0=1 and DR==0, where RegW=0.
  - With no acceptance, RegW=0 next cycle and DR/Reg_In hold their values.
- Forwarding: the register file reads and writes on the same edge, so a same-edge read returns the old value.
  - Each edge: FWD1 <= RegW && (DR==SR1); FWD2 <= RegW && (DR==SR2); FWD_DATA <= Reg_In.
  - The flags are therefore aligned with the ReadReg outputs of the read issued that edge.
- Halt state machine, three states:
  - RUN -> DRAIN when HLT=1 at an edge.
  - DRAIN -> HALTED at the next edge. The write presented during DRAIN commits on that edge.
  - DRAIN -> RUN if HLT=0 at that edge.
  - HALTED -> RUN when HLT=0 at an edge.
  - HALTED=1 only in state HALTED. RegW is always 0 in HALTED.
- CONFLICT_CNT increments on each edge where both VALIDs are high in RUN with HLT=0. It saturates at all-ones.
- A mid-operation HLT never drops an accepted write: an acceptance always produces its RegW pulse.

Test Plan:
- Reset checks:
  - Assert RST_N=0 mid-stream with RegW=1 -> RegW=0, DR=0, FWD1=0, HALTED=0 immediately, with no CLK edge needed.
  - After release, drive both VALID -> L granted first.
- Both VALID held for 4 cycles (A_DR=3/DATA=0xAAAA0000, L_DR=4/DATA=0x5555FFFF) -> grants L, A, L, A. RegW high 4 consecutive cycles with DR 4, 3, 4, 3. CONFLICT_CNT=4.
- L_VALID alone with L_DR=0, DATA=0x1234 -> L_READY=1 and RegW=0 next cycle (DROP_R0=1).
  - With DROP_R0=0 -> RegW=1, DR=0.
- A write with DR=7, DATA=0xDEADBEEF on the same cycle SR1=7, SR2=8 -> next cycle FWD1=1, FWD2=0, FWD_DATA=0xDEADBEEF.
- A_VALID held, raise HLT one cycle after acceptance, hold HLT 3 cycles:
  - Pending write still commits (RegW=1 once).
  - A_READY=0 while HLT=1.
  - HALTED=1 from the 2nd HLT edge.
  - Drop HLT -> HALTED=0 and A accepted next cycle.
- Force CNT_W=2 and keep both VALID high 6 cycles -> CONFLICT_CNT reads 1, 2, 3, 3, 3, 3.
